// File: rtl/axi_pkg.sv
// Shared encodings, FSM states and data pattern for the axi_mst generator.
package axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    AW,
    W,
    B,
    AR,
    R
  } state_e;

  function automatic logic [63:0] pat(
    input logic [63:0] addr,
    input logic [15:0] iter
  );
    return addr + {48'd0, iter};
  endfunction

endpackage

// File: rtl/axi_mst_beat_cnt.sv
// Beat index within a burst, with a flag for the final beat.
module axi_mst_beat_cnt
  import axi_pkg::*;
#(
  parameter int LEN = 8,
  parameter int CW  = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == CW'(LEN - 1));
  assign cnt_o  = cnt_q;

  // Wrap to zero on the last beat so the next phase starts clean.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || (inc_i && last_o)) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_mst.sv
// AXI4 master loop: write one INCR burst, read it back, advance address.
// Define AXI_MST_RD_CHECK_EN to add the read-data comparator (rd_data_err).
module axi_mst
  import axi_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          ID_W      = 4,
  parameter int          BURST_LEN = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ADDR_SPAN = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [ID_W-1:0]   bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic              resp_err,
`ifdef AXI_MST_RD_CHECK_EN
  output logic              rd_data_err,
`endif
  output logic [15:0]       iter_cnt
);

  localparam int SZ = $clog2(DATA_W / 8);
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned BYTES = BURST_LEN * (DATA_W / 8);
  localparam logic [ADDR_W-1:0] A_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] A_END  = ADDR_W'(BASE_ADDR + ADDR_SPAN);
  localparam logic [ADDR_W-1:0] A_STEP = ADDR_W'(BYTES);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_sum, beat_addr;
  logic [15:0]       iter_q;
  logic              awvalid_q, wvalid_q, bready_q;
  logic              arvalid_q, rready_q, resp_err_q;
  logic [CW-1:0]     beat;
  logic              beat_last, beat_inc, beat_clr;
  logic [DATA_W-1:0] beat_data;
  logic              w_fire, r_fire;

  assign w_fire   = wvalid_q && wready;
  assign r_fire   = rready_q && rvalid;
  assign beat_inc = w_fire || r_fire;
  assign beat_clr = (state_q == IDLE);

  axi_mst_beat_cnt #(
    .LEN (BURST_LEN),
    .CW  (CW)
  ) u_beat (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (beat_clr),
    .inc_i  (beat_inc),
    .cnt_o  (beat),
    .last_o (beat_last)
  );

  // Same pattern drives W data and the expected R data.
  assign beat_addr = addr_q + (ADDR_W'(beat) << SZ);
  assign beat_data = DATA_W'(pat(64'(beat_addr), iter_q));

  assign addr_sum = addr_q + A_STEP;
  assign addr_d   = (addr_sum == A_END) ? A_BASE : addr_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= A_BASE;
      iter_q     <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          awvalid_q <= 1'b1;
          state_q   <= AW;
        end
        AW: if (awready) begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b1;
          state_q   <= W;
        end
        W: if (w_fire && beat_last) begin
          wvalid_q <= 1'b0;
          bready_q <= 1'b1;
          state_q  <= B;
        end
        B: if (bvalid) begin
          if (bresp != RESP_OKAY) resp_err_q <= 1'b1;
          bready_q  <= 1'b0;
          arvalid_q <= 1'b1;
          state_q   <= AR;
        end
        AR: if (arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= R;
        end
        R: if (r_fire) begin
          if (rresp != RESP_OKAY || rlast != beat_last) begin
            resp_err_q <= 1'b1;
          end
          // A misplaced rlast still closes the iteration.
          if (rlast || beat_last) begin
            rready_q <= 1'b0;
            iter_q   <= iter_q + 16'd1;
            addr_q   <= addr_d;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign awid     = '0;
  assign awaddr   = addr_q;
  assign awlen    = 8'(BURST_LEN - 1);
  assign awsize   = 3'(SZ);
  assign awburst  = BURST_INCR;
  assign awvalid  = awvalid_q;
  assign wdata    = beat_data;
  assign wstrb    = '1;
  assign wlast    = wvalid_q && beat_last;
  assign wvalid   = wvalid_q;
  assign bready   = bready_q;
  assign arid     = '0;
  assign araddr   = addr_q;
  assign arlen    = 8'(BURST_LEN - 1);
  assign arsize   = 3'(SZ);
  assign arburst  = BURST_INCR;
  assign arvalid  = arvalid_q;
  assign rready   = rready_q;
  assign resp_err = resp_err_q;
  assign iter_cnt = iter_q;

`ifdef AXI_MST_RD_CHECK_EN
  logic rd_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_err_q <= 1'b0;
    end else if (r_fire && (rdata != beat_data || rid != '0)) begin
      rd_err_q <= 1'b1;
    end
  end

  assign rd_data_err = rd_err_q;

  logic unused_in;
  assign unused_in = ^bid;
`else
  logic unused_in;
  assign unused_in = ^{bid, rid, rdata};
`endif

endmodule
